// File: rtl/credit_ledger.sv
// Credit accumulator downstream of the coin acceptor: saturating coin adds,
// vend grant/deny against a price, and refund as a train of fixed-width change pulses.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | accept coins, arbitrate refund and vend requests
//   PAYOUT_HI | change_pulse high, one CHANGE_UNIT already deducted
//   PAYOUT_LO | change_pulse low gap; then next unit or back to IDLE
module credit_ledger #(
    parameter int CREDIT_W    = 10,
    parameter int CHANGE_UNIT = 5,
    parameter int PULSE_HIGH  = 4,
    parameter int PULSE_LOW   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [5:0]          coin_value,
    input  logic                vend_req,
    input  logic [CREDIT_W-1:0] price,
    input  logic                refund_req,
    output logic [CREDIT_W-1:0] credit,
    output logic                vend_grant,
    output logic                vend_deny,
    output logic                change_pulse,
    output logic                busy,
    output logic                sat_flag
);

    localparam int T_MAX   = (PULSE_HIGH > PULSE_LOW) ? PULSE_HIGH : PULSE_LOW;
    localparam int TIMER_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [CREDIT_W:0]  MAX_CREDIT = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [CREDIT_W:0]  UNIT       = (CREDIT_W+1)'(CHANGE_UNIT);
    localparam logic [TIMER_W-1:0] HI_LOAD    = TIMER_W'(PULSE_HIGH - 1);
    localparam logic [TIMER_W-1:0] LO_LOAD    = TIMER_W'(PULSE_LOW - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PAYOUT_HI = 2'd1,
        PAYOUT_LO = 2'd2
    } state_t;

    state_t               state;
    logic [TIMER_W-1:0]   timer;

    logic                 unit_avail;
    logic                 timer_done;
    logic                 start_pulse;
    logic                 payout_done;
    logic                 sat_hit;
    logic [CREDIT_W:0]    coin_amt;
    logic [CREDIT_W:0]    sum;
    logic [CREDIT_W-1:0]  credit_coin;

    // One extra bit of headroom lets the clamp see an overflowing coin add.
    always_comb begin
        unit_avail  = {1'b0, credit} >= UNIT;
        timer_done  = (timer == '0);
        start_pulse = 1'b0;
        payout_done = 1'b0;
        case (state)
            IDLE:      start_pulse = !coin_valid && refund_req && unit_avail;
            PAYOUT_LO: begin
                start_pulse = timer_done && unit_avail;
                payout_done = timer_done && !unit_avail;
            end
            default:   ;
        endcase
        coin_amt    = coin_valid ? (CREDIT_W+1)'(coin_value) : '0;
        sum         = {1'b0, credit} + coin_amt - (start_pulse ? UNIT : '0);
        sat_hit     = (sum > MAX_CREDIT);
        credit_coin = sat_hit ? {CREDIT_W{1'b1}} : sum[CREDIT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            credit       <= '0;
            vend_grant   <= 1'b0;
            vend_deny    <= 1'b0;
            change_pulse <= 1'b0;
            busy         <= 1'b0;
            sat_flag     <= 1'b0;
        end else begin
            credit     <= credit_coin;
            vend_grant <= 1'b0;
            vend_deny  <= 1'b0;

            if (sat_hit)
                sat_flag <= 1'b1;
            else if (payout_done)
                sat_flag <= 1'b0;

            if (start_pulse) begin
                state        <= PAYOUT_HI;
                change_pulse <= 1'b1;
                busy         <= 1'b1;
                timer        <= HI_LOAD;
            end else begin
                case (state)
                    IDLE: begin
                        // Coins and refund requests both outrank a vend in the same cycle.
                        if (!coin_valid && !refund_req && vend_req) begin
                            if (credit >= price) begin
                                credit     <= credit - price;
                                vend_grant <= 1'b1;
                            end else begin
                                vend_deny  <= 1'b1;
                            end
                        end
                    end
                    PAYOUT_HI: begin
                        if (timer_done) begin
                            state        <= PAYOUT_LO;
                            change_pulse <= 1'b0;
                            timer        <= LO_LOAD;
                        end else begin
                            timer <= timer - TIMER_W'(1);
                        end
                    end
                    PAYOUT_LO: begin
                        if (timer_done) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            timer <= timer - TIMER_W'(1);
                        end
                    end
                    default: begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        change_pulse <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_credit_ledger.sv
// Self-checking bench for credit_ledger: table of single-cycle vectors followed by
// hand-written refund, coin-during-payout and reset-during-payout sequences.
module tb_credit_ledger;

    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          coin_valid = 1'b0;
    logic [5:0]    coin_value = '0;
    logic          vend_req = 1'b0;
    logic [CW-1:0] price = '0;
    logic          refund_req = 1'b0;
    logic [CW-1:0] credit;
    logic          vend_grant;
    logic          vend_deny;
    logic          change_pulse;
    logic          busy;
    logic          sat_flag;

    credit_ledger #(
        .CREDIT_W(CW), .CHANGE_UNIT(5), .PULSE_HIGH(4), .PULSE_LOW(4)
    ) dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_value(coin_value),
        .vend_req(vend_req), .price(price), .refund_req(refund_req),
        .credit(credit), .vend_grant(vend_grant), .vend_deny(vend_deny),
        .change_pulse(change_pulse), .busy(busy), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] credit;
        logic          grant;
        logic          deny;
        logic          pulse;
        logic          busy;
        logic          sat;
    } outs_t;

    typedef struct {
        logic          r;
        logic          cv;
        logic [5:0]    val;
        logic          vr;
        logic [CW-1:0] pr;
        logic          rf;
        outs_t         exp;
    } vec_t;

    vec_t  vecs[$];
    outs_t sb[$];
    int    passed = 0;
    int    total  = 0;

    function automatic outs_t o(int c, bit g = 0, bit d = 0, bit p = 0, bit b = 0, bit s = 0);
        outs_t r;
        r.credit = CW'(c);
        r.grant  = g;
        r.deny   = d;
        r.pulse  = p;
        r.busy   = b;
        r.sat    = s;
        return r;
    endfunction

    function automatic void add(bit r, bit cv, int val, bit vr, int pr, bit rf, outs_t e);
        vec_t v;
        v.r   = r;
        v.cv  = cv;
        v.val = 6'(val);
        v.vr  = vr;
        v.pr  = CW'(pr);
        v.rf  = rf;
        v.exp = e;
        vecs.push_back(v);
    endfunction

    task automatic drive(bit r, bit cv, int val, bit vr, int pr, bit rf);
        rst        = r;
        coin_valid = cv;
        coin_value = 6'(val);
        vend_req   = vr;
        price      = CW'(pr);
        refund_req = rf;
    endtask

    // Expectation goes into the scoreboard with the stimulus, comes out after the edge.
    task automatic cycle(string name, outs_t e);
        outs_t want;
        sb.push_back(e);
        @(posedge clk);
        #1;
        want = sb.pop_front();
        total++;
        if (credit === want.credit && vend_grant === want.grant && vend_deny === want.deny &&
            change_pulse === want.pulse && busy === want.busy && sat_flag === want.sat)
            passed++;
        else
            $display("FAIL %s: got credit=%0d grant=%b deny=%b pulse=%b busy=%b sat=%b, expected credit=%0d grant=%b deny=%b pulse=%b busy=%b sat=%b",
                     name, credit, vend_grant, vend_deny, change_pulse, busy, sat_flag,
                     want.credit, want.grant, want.deny, want.pulse, want.busy, want.sat);
    endtask

    task automatic check_int(string name, int got, int want);
        total++;
        if (got == want) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, want);
    endtask

    initial begin
        int   npulse;
        logic prev;
        outs_t e;

        // reset, vend, priority and refund-residue vectors
        add(1, 0, 0,  0, 0,  0, o(0));
        add(1, 0, 0,  0, 0,  0, o(0));
        add(0, 0, 0,  0, 0,  0, o(0));
        add(0, 1, 10, 1, 5,  0, o(10));
        add(0, 0, 0,  1, 5,  0, o(5, 1, 0));
        add(0, 0, 0,  1, 15, 0, o(5, 0, 1));
        add(0, 1, 15, 0, 0,  0, o(20));
        add(0, 0, 0,  1, 15, 0, o(5, 1, 0));
        add(0, 0, 0,  1, 15, 0, o(5, 0, 1));
        add(0, 0, 0,  1, 0,  0, o(5, 1, 0));
        add(0, 1, 0,  0, 0,  0, o(5));
        add(0, 0, 0,  1, 3,  0, o(2, 1, 0));
        add(0, 0, 0,  0, 0,  1, o(2));
        add(0, 0, 0,  1, 2,  0, o(0, 1, 0));
        add(0, 0, 0,  1, 1,  0, o(0, 0, 1));
        add(0, 1, 7,  0, 0,  1, o(7));
        add(0, 0, 0,  0, 0,  0, o(7));
        add(0, 0, 0,  1, 7,  0, o(0, 1, 0));
        // saturation: 17 coins of 63
        for (int k = 1; k <= 17; k++)
            add(0, 1, 63, 0, 0, 0, o((k <= 16) ? 63 * k : 1023, 0, 0, 0, 0, k == 17));
        add(0, 1, 63, 0, 0,    0, o(1023, 0, 0, 0, 0, 1));
        add(0, 1, 1,  0, 0,    0, o(1023, 0, 0, 0, 0, 1));
        add(0, 0, 0,  1, 1006, 0, o(17, 1, 0, 0, 0, 1));

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].cv, int'(vecs[i].val), vecs[i].vr, int'(vecs[i].pr), vecs[i].rf);
            cycle($sformatf("vec%0d", i), vecs[i].exp);
        end

        // refund of 17: three pulses 4 high / 4 low, vend held throughout is ignored
        drive(0, 0, 0, 0, 0, 1);
        cycle("t5_start", o(12, 0, 0, 1, 1, 1));
        drive(0, 0, 0, 1, 0, 0);
        npulse = 1;
        prev   = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            if (i < 24) e = o(17 - 5 * (i / 8 + 1), 0, 0, (i % 8) < 4, 1, 1);
            else        e = o(2);
            cycle($sformatf("t5_cyc%0d", i), e);
            if (change_pulse && !prev) npulse++;
            prev = change_pulse;
        end
        drive(0, 0, 0, 0, 0, 0);
        check_int("t5_pulse_count", npulse, 3);
        cycle("t5_after", o(2));

        // coin arriving during the first change pulse is paid out too
        drive(0, 1, 3, 0, 0, 0);
        cycle("t6_fill", o(5));
        drive(0, 0, 0, 0, 0, 1);
        cycle("t6_start", o(0, 0, 0, 1, 1, 0));
        drive(0, 1, 5, 0, 0, 0);
        cycle("t6_coin", o(5, 0, 0, 1, 1, 0));
        drive(0, 0, 0, 0, 0, 0);
        npulse = 1;
        prev   = 1'b1;
        for (int i = 2; i <= 16; i++) begin
            if (i < 16) e = o((i < 8) ? 5 : 0, 0, 0, (i % 8) < 4, 1, 0);
            else        e = o(0);
            cycle($sformatf("t6_cyc%0d", i), e);
            if (change_pulse && !prev) npulse++;
            prev = change_pulse;
        end
        check_int("t6_pulse_count", npulse, 2);

        // reset in PAYOUT_HI aborts the payout at once
        drive(0, 1, 20, 0, 0, 0);
        cycle("rst_fill", o(20));
        drive(0, 0, 0, 0, 0, 1);
        cycle("rst_start", o(15, 0, 0, 1, 1, 0));
        drive(0, 0, 0, 0, 0, 0);
        cycle("rst_hi", o(15, 0, 0, 1, 1, 0));
        drive(1, 0, 0, 0, 0, 0);
        cycle("rst_abort", o(0));
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            cycle($sformatf("rst_quiet%0d", i), o(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
